// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with a programmable wait-state FSM, per-lane write merge and
// out-of-window detection. Bus state resets asynchronously; memory contents never reset.
module avalon_wait_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err_oob
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rd_hold_q, rd_hold_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req;
    logic        wait_c;
    logic        complete_c;
    logic        do_access;
    logic        mem_we;
    logic [31:0] word_idx;
    logic        in_range;
    logic [31:0] rd_val;

    assign req      = read | write;
    assign word_idx = (address - BASE_ADDR) >> 2;
    assign in_range = word_idx < 32'(DEPTH_WORDS);
    assign rd_val   = in_range ? mem[word_idx[AW-1:0]] : 32'h0;

    // IDLE already counts as the first stall cycle, so WAIT lasts WAIT_STATES-1 cycles
    // and the ACK cycle lands exactly WAIT_STATES cycles after the request appears.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_c     = 1'b0;
        complete_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        complete_c = 1'b1;
                    end else begin
                        wait_c = 1'b1;
                        if (WAIT_STATES == 1) begin
                            state_d = S_ACK;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = 4'(WAIT_STATES - 2);
                        end
                    end
                end
            end
            S_WAIT: begin
                wait_c = 1'b1;
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                complete_c = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign do_access = complete_c & req & ~reset;
    assign mem_we    = do_access & write & in_range;

    always_comb begin
        rd_hold_d = rd_hold_q;
        err_d     = 1'b0;
        if (do_access) begin
            err_d = ~in_range;
            if (!write) begin
                rd_hold_d = rd_val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            rd_hold_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_hold_q <= rd_hold_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && byteenable[i]) begin
                mem[word_idx[AW-1:0]][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

    assign waitrequest = reset | wait_c;
    assign readdata    = (do_access && !write) ? rd_val : rd_hold_q;
    assign err_oob     = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            if (read && write)
                $display("avalon_wait_ram: warning: read and write both high at %0t, treated as write", $time);
            if (req && $isunknown(address))
                $display("avalon_wait_ram: warning: unknown address with request at %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Randomised bench for avalon_wait_ram: a zero-wait and a two-wait instance checked
// against a word-array reference model of the memory window.
module tb_avalon_wait_ram;

    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          DEPTH = 16;

    logic        clk;
    logic        rst;
    logic [31:0] addr_i  [2];
    logic        rd_i    [2];
    logic        wr_i    [2];
    logic [31:0] wdata_i [2];
    logic [3:0]  be_i    [2];
    logic        wreq_o  [2];
    logic [31:0] rdata_o [2];
    logic        err_o   [2];

    int          ws_of [2] = '{0, 2};
    logic [31:0] ref_mem  [2][DEPTH];
    logic [31:0] ref_hold [2];

    int n_vec = 0;
    int n_err = 0;

    avalon_wait_ram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .reset(rst), .address(addr_i[0]), .read(rd_i[0]), .write(wr_i[0]),
        .writedata(wdata_i[0]), .byteenable(be_i[0]), .waitrequest(wreq_o[0]),
        .readdata(rdata_o[0]), .err_oob(err_o[0]));

    avalon_wait_ram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .INIT_FILE("")) dut2 (
        .clk(clk), .reset(rst), .address(addr_i[1]), .read(rd_i[1]), .write(wr_i[1]),
        .writedata(wdata_i[1]), .byteenable(be_i[1]), .waitrequest(wreq_o[1]),
        .readdata(rdata_o[1]), .err_oob(err_o[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_oob(input logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) / 4;
        return w >= DEPTH;
    endfunction

    // One complete access on instance d; starts after the next rising edge, ends on a falling edge.
    task automatic acc(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
        int          n;
        bit          oob;
        logic [31:0] w;
        logic [31:0] exp;
        @(posedge clk); #1;
        rd_i[d] = rd; wr_i[d] = wr; addr_i[d] = a; wdata_i[d] = wd; be_i[d] = be;
        n = 0;
        @(negedge clk);
        while (wreq_o[d] && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("latency", 32'(n), 32'(ws_of[d]));
        oob = is_oob(a);
        w   = (a - BASE) / 4;
        if (rd && !wr) begin
            exp = oob ? 32'h0 : ref_mem[d][w];
            chk("rdata", rdata_o[d], exp);
            ref_hold[d] = exp;
        end else if (wr && !oob) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[d][w][8*i +: 8] = wd[8*i +: 8];
        end
        @(posedge clk); #1;
        rd_i[d] = 1'b0; wr_i[d] = 1'b0;
        @(negedge clk);
        chk("err_oob", 32'(err_o[d]), 32'(oob));
        chk("rd_hold", rdata_o[d], ref_hold[d]);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            addr_i[d] = BASE; rd_i[d] = 1'b0; wr_i[d] = 1'b0; wdata_i[d] = 32'h0; be_i[d] = 4'h0;
            ref_hold[d] = 32'h0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_wait", 32'(wreq_o[d]), 32'h1);
            chk("rst_rdata", rdata_o[d], 32'h0);
            chk("rst_err", 32'(err_o[d]), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("idle_wait", 32'(wreq_o[d]), 32'h0);

        // fill the window with known data
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < DEPTH; k++)
                acc(d, 1'b0, 1'b1, BASE + 32'(4 * k), $urandom(), 4'hF);

        // reset-vector read with cycle-by-cycle waitrequest on the two-wait instance
        acc(1, 1'b0, 1'b1, BASE, 32'h3C021234, 4'hF);
        @(posedge clk); #1;
        rd_i[1] = 1'b1; addr_i[1] = BASE;
        @(negedge clk); chk("t1_c0_wait", 32'(wreq_o[1]), 32'h1);
        @(negedge clk); chk("t1_c1_wait", 32'(wreq_o[1]), 32'h1);
        @(negedge clk); chk("t1_c2_wait", 32'(wreq_o[1]), 32'h0);
        chk("t1_rdata", rdata_o[1], 32'h3C021234);
        @(posedge clk); #1; rd_i[1] = 1'b0;
        ref_hold[1] = 32'h3C021234;
        @(negedge clk); chk("t1_hold", rdata_o[1], 32'h3C021234);
        acc(1, 1'b1, 1'b0, BASE, 32'h0, 4'h0);

        // byte-lane merge
        for (int d = 0; d < 2; d++) begin
            acc(d, 1'b0, 1'b1, BASE + 32'h10, 32'h11223344, 4'hF);
            acc(d, 1'b0, 1'b1, BASE + 32'h10, 32'hAABBCCDD, 4'b0101);
            acc(d, 1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
            chk("t2_merge", ref_hold[d], 32'h11BB33DD);
        end

        // zero-wait streaming reads, one per cycle
        @(posedge clk); #1;
        rd_i[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr_i[0] = BASE + 32'(4 * k);
            @(negedge clk);
            chk("t3_wait", 32'(wreq_o[0]), 32'h0);
            chk("t3_rdata", rdata_o[0], ref_mem[0][k]);
            @(posedge clk); #1;
        end
        rd_i[0] = 1'b0;
        ref_hold[0] = ref_mem[0][3];
        @(negedge clk); chk("t3_hold", rdata_o[0], ref_hold[0]);

        // out of window
        for (int d = 0; d < 2; d++) begin
            acc(d, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0);
            acc(d, 1'b0, 1'b1, 32'h00000000, 32'hDEADBEEF, 4'hF);
            acc(d, 1'b1, 1'b0, BASE, 32'h0, 4'h0);
        end

        // master abort during WAIT
        @(posedge clk); #1;
        wr_i[1] = 1'b1; addr_i[1] = BASE + 32'h8; wdata_i[1] = 32'h5A5A5A5A; be_i[1] = 4'hF;
        @(posedge clk); #1; wr_i[1] = 1'b0;
        @(negedge clk); chk("t5_abort_wait", 32'(wreq_o[1]), 32'h1);
        @(negedge clk);
        chk("t5_abort_idle", 32'(wreq_o[1]), 32'h0);
        chk("t5_abort_err", 32'(err_o[1]), 32'h0);
        acc(1, 1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0);

        // reset during WAIT
        @(posedge clk); #1;
        wr_i[1] = 1'b1; addr_i[1] = BASE + 32'hC; wdata_i[1] = 32'hA5A5A5A5; be_i[1] = 4'hF;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); chk("t5_rst_wait", 32'(wreq_o[1]), 32'h1);
        @(posedge clk); #1; rst = 1'b0; wr_i[1] = 1'b0;
        ref_hold[0] = 32'h0; ref_hold[1] = 32'h0;
        @(negedge clk); chk("t5_rst_idle", 32'(wreq_o[1]), 32'h0);
        acc(1, 1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'h0);

        // read and write together behave as a write
        for (int d = 0; d < 2; d++) begin
            acc(d, 1'b1, 1'b1, BASE + 32'h20, 32'hCAFEF00D, 4'hF);
            acc(d, 1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
            chk("t6_rdata", ref_hold[d], 32'hCAFEF00D);
        end

        // random traffic
        for (int t = 0; t < 300; t++) begin
            int          d;
            int          kind;
            logic [31:0] a;
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            if (kind < 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            else if (kind < 9) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 64));
            else a = $urandom();
            case ($urandom_range(0, 4))
                0, 1:    acc(d, 1'b1, 1'b0, a, 32'h0, 4'h0);
                2, 3:    acc(d, 1'b0, 1'b1, a, $urandom(), 4'($urandom_range(0, 15)));
                default: acc(d, 1'b1, 1'b1, a, $urandom(), 4'($urandom_range(0, 15)));
            endcase
        end

        // final sweep of both windows
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < DEPTH; k++)
                acc(d, 1'b1, 1'b0, BASE + 32'(4 * k), 32'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
